// File: rtl/rv32i_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_timer_if
//  Description : Data-port bus bundle between the RV32I core (master) and the
//                machine timer (slave).
//                  address     byte address (core daddress)
//                  write       write strobe
//                  writedata   write data
//                  byteenable  byte lane enables
//                  read        read strobe
//                  readdata    read data, zero unless a read completes
//                  waitrequest stall for a read access
//  Revision    : 1.0  initial release
// ============================================================================
interface rv32i_timer_if;
  logic [31:0] address;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, write, writedata, byteenable, read,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, write, writedata, byteenable, read,
    output readdata, waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/rv32i_timer.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_timer
//  Description : Memory-mapped 64-bit machine timer (mtime / mtimecmp) with a
//                programmable prescaler and a level interrupt to the core.
//  Ports       : clk      system clock
//                reset_n  asynchronous active-low reset
//                bus      data-port slave (address, write, writedata,
//                         byteenable, read, readdata, waitrequest)
//                irq      timer interrupt, registered
//  Register map (word offset = address[4:2]):
//                0 MTIME_LO   1 MTIME_HI   2 MTIMECMP_LO   3 MTIMECMP_HI
//                4 CTRL  (bit0 CNT_EN, bit1 IRQ_EN, bits15:8 PRESCALE)
//                5..7 read as zero, writes ignored
//  Revision    : 1.0  initial release
// ============================================================================
module rv32i_timer #(
  parameter logic [31:0] BASE_ADDR        = 32'hAFFFFFE0,
  parameter logic [7:0]  PRESCALE_DEFAULT = 8'd0
) (
  input  logic         clk,
  input  logic         reset_n,
  rv32i_timer_if.slave bus,
  output logic         irq
);

  localparam logic [2:0] c_off_mtime_lo = 3'd0;
  localparam logic [2:0] c_off_mtime_hi = 3'd1;
  localparam logic [2:0] c_off_cmp_lo   = 3'd2;
  localparam logic [2:0] c_off_cmp_hi   = 3'd3;
  localparam logic [2:0] c_off_ctrl     = 3'd4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } rd_state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_cnt_en;
  logic        r_irq_en;
  logic [7:0]  r_prescale;
  logic [7:0]  r_pcount;
  logic [31:0] r_shadow_hi;
  logic [31:0] r_rdbuf;
  rd_state_t   r_state;
  logic        r_irq;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic        w_sel;
  logic [2:0]  w_off;
  logic        w_wr;
  logic        w_wr_mtime_lo;
  logic        w_wr_mtime_hi;
  logic        w_wr_cmp_lo;
  logic        w_wr_cmp_hi;
  logic        w_wr_ctrl;
  logic        w_wr_prescale;
  logic        w_rd_start;
  logic        w_tick;
  logic [31:0] w_mask;
  logic [31:0] w_rd_mux;
  logic        w_unused_addr;

  assign w_sel = (bus.address[31:5] == BASE_ADDR[31:5]);
  assign w_off = bus.address[4:2];
  assign w_wr  = bus.write & w_sel;

  assign w_wr_mtime_lo = w_wr & (w_off == c_off_mtime_lo);
  assign w_wr_mtime_hi = w_wr & (w_off == c_off_mtime_hi);
  assign w_wr_cmp_lo   = w_wr & (w_off == c_off_cmp_lo);
  assign w_wr_cmp_hi   = w_wr & (w_off == c_off_cmp_hi);
  assign w_wr_ctrl     = w_wr & (w_off == c_off_ctrl);
  // Any write that touches the PRESCALE byte restarts the prescaler phase,
  // even if the value written equals the current one.
  assign w_wr_prescale = w_wr_ctrl & bus.byteenable[1];

  // Byte-lane mask: a set byte means that lane takes writedata.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_mask[gi*8 +: 8] = {8{bus.byteenable[gi]}};
    end
  endgenerate

  // Word-aligned accesses only; the low address bits carry no meaning.
  assign w_unused_addr = &{1'b0, bus.address[1:0]};

  // Prescaler terminal count: one mtime increment per PRESCALE+1 clocks.
  assign w_tick = r_cnt_en & (r_pcount == r_prescale);

  assign w_rd_start = bus.read & w_sel & (r_state == ST_IDLE);

  // Read source selection at capture time. MTIME_HI returns the shadow so
  // that a LO-then-HI pair always forms one coherent 64-bit sample.
  always_comb begin
    w_rd_mux = 32'd0;
    case (w_off)
      c_off_mtime_lo: w_rd_mux = r_mtime[31:0];
      c_off_mtime_hi: w_rd_mux = r_shadow_hi;
      c_off_cmp_lo:   w_rd_mux = r_mtimecmp[31:0];
      c_off_cmp_hi:   w_rd_mux = r_mtimecmp[63:32];
      c_off_ctrl:     w_rd_mux = {16'd0, r_prescale, 6'd0, r_irq_en, r_cnt_en};
      default:        w_rd_mux = 32'd0;
    endcase
  end

  // --------------------------------------------------------------------------
  // mtime and prescaler
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mtime  <= 64'd0;
      r_pcount <= 8'd0;
    end else begin
      // A software write to either half wins over the tick for the whole
      // 64-bit value: the other half holds and no carry is generated.
      if (w_wr_mtime_lo || w_wr_mtime_hi) begin
        if (w_wr_mtime_lo)
          r_mtime[31:0]  <= (r_mtime[31:0] & ~w_mask) | (bus.writedata & w_mask);
        if (w_wr_mtime_hi)
          r_mtime[63:32] <= (r_mtime[63:32] & ~w_mask) | (bus.writedata & w_mask);
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end

      if (w_wr_prescale) begin
        r_pcount <= 8'd0;
      end else if (r_cnt_en) begin
        r_pcount <= w_tick ? 8'd0 : r_pcount + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // mtimecmp and CTRL
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_cnt_en   <= 1'b1;
      r_irq_en   <= 1'b0;
      r_prescale <= PRESCALE_DEFAULT;
    end else begin
      if (w_wr_cmp_lo)
        r_mtimecmp[31:0]  <= (r_mtimecmp[31:0] & ~w_mask) | (bus.writedata & w_mask);
      if (w_wr_cmp_hi)
        r_mtimecmp[63:32] <= (r_mtimecmp[63:32] & ~w_mask) | (bus.writedata & w_mask);
      if (w_wr_ctrl && bus.byteenable[0]) begin
        r_cnt_en <= bus.writedata[0];
        r_irq_en <= bus.writedata[1];
      end
      if (w_wr_prescale)
        r_prescale <= bus.writedata[15:8];
    end
  end

  // --------------------------------------------------------------------------
  // Read FSM: IDLE captures into the buffer while stalling one cycle, DATA
  // presents the buffer and always falls back to IDLE.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_rdbuf     <= 32'd0;
      r_shadow_hi <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rd_start) begin
            r_rdbuf <= w_rd_mux;
            if (w_off == c_off_mtime_lo)
              r_shadow_hi <= r_mtime[63:32];
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Interrupt: compare on current register values, one clock of latency.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq_en & (r_mtime >= r_mtimecmp);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Gating with reset_n makes the stall drop the instant reset is asserted,
  // even while the core still holds read.
  assign bus.waitrequest = reset_n & w_rd_start;
  assign bus.readdata    = (r_state == ST_DATA && bus.read && w_sel) ? r_rdbuf : 32'd0;
  assign irq             = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32i_timer
//  Description : Self-checking bench for rv32i_timer: register vector table,
//                directed corner sequences and random bus traffic compared
//                against a behavioural model of the timer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rv32i_timer;

  localparam logic [31:0] BASE = 32'hAFFFFFE0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic irq;

  rv32i_timer_if bus ();

  rv32i_timer #(
    .BASE_ADDR        (BASE),
    .PRESCALE_DEFAULT (8'd0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit [63:0] m_time;
  bit [63:0] m_cmp;
  bit        m_cnt_en;
  bit        m_irq_en;
  int        m_pre;
  int        m_pc;
  bit [31:0] m_shadow;
  bit        m_irq;

  typedef struct {
    int          off;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] wd, input bit [3:0] be);
    bit [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_time   = 64'd0;
    m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
    m_cnt_en = 1'b1;
    m_irq_en = 1'b0;
    m_pre    = 0;
    m_pc     = 0;
    m_shadow = 32'd0;
    m_irq    = 1'b0;
  endtask

  // One rising edge worth of timer behaviour, from the bus inputs in force.
  task automatic model_edge();
    bit sel, wr, tick, nirq;
    int off;
    sel  = (bus.address[31:5] == BASE[31:5]);
    off  = int'(bus.address[4:2]);
    wr   = bus.write && sel;
    nirq = m_irq_en && (m_time >= m_cmp);
    tick = m_cnt_en && (m_pc == m_pre);

    if (wr && off == 4 && bus.byteenable[1]) m_pc = 0;
    else if (m_cnt_en) m_pc = (m_pc + 1) % (m_pre + 1);

    if (wr && off == 0)
      m_time[31:0] = merge(m_time[31:0], bus.writedata, bus.byteenable);
    else if (wr && off == 1)
      m_time[63:32] = merge(m_time[63:32], bus.writedata, bus.byteenable);
    else if (tick)
      m_time = m_time + 64'd1;

    if (wr && off == 2) m_cmp[31:0]  = merge(m_cmp[31:0], bus.writedata, bus.byteenable);
    if (wr && off == 3) m_cmp[63:32] = merge(m_cmp[63:32], bus.writedata, bus.byteenable);
    if (wr && off == 4) begin
      if (bus.byteenable[0]) begin
        m_cnt_en = bus.writedata[0];
        m_irq_en = bus.writedata[1];
      end
      if (bus.byteenable[1]) m_pre = int'(bus.writedata[15:8]);
    end
    m_irq = nirq;
  endtask

  function automatic bit [31:0] model_reg(input int off);
    case (off)
      0:       return m_time[31:0];
      1:       return m_shadow;
      2:       return m_cmp[31:0];
      3:       return m_cmp[63:32];
      4:       return {16'd0, 8'(m_pre), 6'd0, m_irq_en, m_cnt_en};
      default: return 32'd0;
    endcase
  endfunction

  task automatic bus_idle();
    bus.address    = 32'd0;
    bus.write      = 1'b0;
    bus.writedata  = 32'd0;
    bus.byteenable = 4'd0;
    bus.read       = 1'b0;
  endtask

  task automatic tick_clk();
    @(posedge clk);
    model_edge();
    #1;
    check("irq", irq, m_irq);
  endtask

  task automatic do_write(input int off, input logic [31:0] wd, input logic [3:0] be);
    bus.address    = BASE + 32'(off * 4);
    bus.writedata  = wd;
    bus.byteenable = be;
    bus.write      = 1'b1;
    tick_clk();
    bus_idle();
  endtask

  // Two-cycle read: one stall cycle, then data; read drops before DATA ends.
  task automatic do_read(input int off, output logic [31:0] val);
    logic [31:0] exp;
    bus.address = BASE + 32'(off * 4);
    bus.read    = 1'b1;
    #1;
    check($sformatf("rd%0d_wait_hi", off), bus.waitrequest, 1'b1);
    check($sformatf("rd%0d_data_stall", off), bus.readdata, 32'd0);
    exp = model_reg(off);
    if (off == 0) m_shadow = m_time[63:32];
    tick_clk();
    check($sformatf("rd%0d_wait_lo", off), bus.waitrequest, 1'b0);
    check($sformatf("rd%0d_data", off), bus.readdata, exp);
    val = bus.readdata;
    bus.read = 1'b0;
    tick_clk();
    bus_idle();
  endtask

  task automatic do_read_unsel();
    bus.address = BASE + 32'h40;
    bus.read    = 1'b1;
    #1;
    check("unsel_wait", bus.waitrequest, 1'b0);
    check("unsel_data", bus.readdata, 32'd0);
    tick_clk();
    check("unsel_wait2", bus.waitrequest, 1'b0);
    check("unsel_data2", bus.readdata, 32'd0);
    bus_idle();
  endtask

  initial begin
    logic [31:0] v, lo, hi;
    logic [31:0] wd;
    int off, r;

    // Cumulative register vectors: {offset, byteenable, writedata, readback}
    tbl[0]  = '{2, 4'hF, 32'h12345678, 32'h12345678};
    tbl[1]  = '{2, 4'h1, 32'hAAAAAA55, 32'h12345655};
    tbl[2]  = '{2, 4'h6, 32'h00BBCC00, 32'h12BBCC55};
    tbl[3]  = '{3, 4'h8, 32'h7F000000, 32'h7FFFFFFF};
    tbl[4]  = '{3, 4'h0, 32'h00000000, 32'h7FFFFFFF};
    tbl[5]  = '{4, 4'hF, 32'hFFFFFFFF, 32'h0000FF03};
    tbl[6]  = '{4, 4'h1, 32'h00000000, 32'h0000FF00};
    tbl[7]  = '{4, 4'h2, 32'h00000300, 32'h00000300};
    tbl[8]  = '{5, 4'hF, 32'hFFFFFFFF, 32'h00000000};
    tbl[9]  = '{6, 4'hF, 32'hFFFFFFFF, 32'h00000000};
    tbl[10] = '{7, 4'hF, 32'hFFFFFFFF, 32'h00000000};

    bus_idle();
    model_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_wait", bus.waitrequest, 1'b0);
    check("reset_data", bus.readdata, 32'd0);
    check("reset_irq", irq, 1'b0);
    reset_n = 1'b1;

    // 1: free-running count after reset
    repeat (10) tick_clk();
    do_read(0, v);
    check("t1_mtime_10", v, 32'd10);
    check("t1_irq", irq, 1'b0);

    // Register vector table
    for (int i = 0; i < 11; i++) begin
      do_write(tbl[i].off, tbl[i].wd, tbl[i].be);
      do_read(tbl[i].off, v);
      check($sformatf("vec%0d", i), v, tbl[i].exp);
    end

    // 2: compare match and release
    do_write(4, 32'h0000_0000, 4'hF);
    do_write(1, 32'd0, 4'hF);
    do_write(0, 32'd0, 4'hF);
    do_write(3, 32'd0, 4'hF);
    do_write(2, 32'd20, 4'hF);
    do_write(4, 32'h0000_0003, 4'hF);
    repeat (30) tick_clk();
    check("t2_irq_high", irq, 1'b1);
    do_write(2, 32'hFFFF_FFFF, 4'hF);
    tick_clk();
    check("t2_irq_low", irq, 1'b0);

    // 3: coherent 64-bit read across the low-word rollover
    do_write(4, 32'h0000_0001, 4'hF);
    do_write(1, 32'd0, 4'hF);
    do_write(0, 32'hFFFF_FFFF, 4'hF);
    do_read(0, lo);
    do_read(1, hi);
    check("t3_lo", lo, 32'hFFFF_FFFF);
    check("t3_hi", hi, 32'd0);
    do_read(0, lo);
    do_read(1, hi);
    check("t3_hi_after", hi, 32'd1);

    // 4: prescale 3, then counting frozen
    do_write(4, 32'h0000_0301, 4'hF);
    do_read(0, v);
    repeat (16) tick_clk();
    do_read(0, v);
    do_write(4, 32'h0000_0300, 4'hF);
    do_read(0, v);
    repeat (50) tick_clk();
    do_read(0, v);

    // 5: partial write on a tick cycle suppresses the increment
    do_write(4, 32'h0000_0001, 4'hF);
    do_write(1, 32'h0000_0001, 4'hF);
    do_write(0, 32'h1234_5678, 4'hF);
    do_write(0, 32'hAAAA_AA55, 4'b0001);
    do_read(0, v);
    check("t5_lo", v, 32'h1234_5655);
    do_read(1, v);
    check("t5_hi", v, 32'h0000_0001);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        tick_clk();
      end else if (r <= 5) begin
        off = $urandom_range(0, 7);
        wd  = $urandom;
        if (off == 4) wd[15:8] = 8'($urandom_range(0, 3));
        do_write(off, wd, 4'($urandom_range(0, 15)));
      end else if (r <= 7) begin
        do_read($urandom_range(0, 7), v);
      end else if (r == 8) begin
        do_read(0, v);
        do_read(1, v);
      end else begin
        do_read_unsel();
      end
    end

    // 6: unselected read, then reset during a read stall
    do_read_unsel();
    bus.address = BASE;
    bus.read    = 1'b1;
    #1;
    check("t6_wait_before", bus.waitrequest, 1'b1);
    reset_n = 1'b0;
    #1;
    check("t6_wait_reset", bus.waitrequest, 1'b0);
    check("t6_irq_reset", irq, 1'b0);
    model_reset();
    bus_idle();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    do_read(4, v);
    check("t6_ctrl", v, 32'h0000_0001);
    do_read(2, v);
    check("t6_cmp_lo", v, 32'hFFFF_FFFF);
    do_read(3, v);
    check("t6_cmp_hi", v, 32'hFFFF_FFFF);
    do_read(0, v);
    do_read(1, v);
    check("t6_mtime_hi", v, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv32i_timer.md
Name: rv32i_timer

Overview:
Memory-mapped machine timer on the RV32I core's data port. Consumes the core's daddress/dwrite/dread/dbyteenable/dwritedata and returns dreaddata/dwaitrequest. Drives the core's irq input from a 64-bit mtime/mtimecmp compare. Sits directly downstream of rv32i_cpu_core on the data bus, alongside data memory, with an OR-combining interconnect.

Parameters:
BASE_ADDR, 32'hAFFFFFE0, 32-byte-aligned base of the register window.
PRESCALE_DEFAULT, 8'd0, reset value of prescale field (tick every PRESCALE+1 clocks).

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
address  input  32  byte address (core daddress)
write  input  1  write strobe (core dwrite)
writedata  input  32  write data
byteenable  input  4  byte lane enables
read  input  1  read strobe (core dread)
readdata  output  32  read data, valid when read & ~waitrequest, else 0
waitrequest  output  1  stall for read access
irq  output  1  timer interrupt to core

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous and active-low; all flops clear on reset_n low, regardless of clk.
- Select: sel = (address[31:5] == BASE_ADDR[31:5]). Offset = address[4:2].
- Register map:
  - 0: MTIME_LO.
  - 1: MTIME_HI.
  - 2: MTIMECMP_LO.
  - 3: MTIMECMP_HI.
  - 4: CTRL (bit0 CNT_EN, bit1 IRQ_EN, bits15:8 PRESCALE).
  - 5-7: read 0, writes ignored.
- Reset values:
  - mtime = 0.
  - mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF.
  - CNT_EN = 1, IRQ_EN = 0, PRESCALE = PRESCALE_DEFAULT.
  - prescale counter = 0, shadow_hi = 0.
  - readdata = 0, waitrequest = 0, irq = 0, read state = IDLE.
- Writes: zero wait states; take effect on the edge where write & sel is high. Per-byte update per byteenable; CTRL bits other than 0, 1 and 15:8 are ignored.
- Read FSM (2 states):
  - IDLE: read & sel -> waitrequest=1 (combinational), register selected data into a read buffer, go DATA.
  - DATA: waitrequest=0, readdata = buffer, return to IDLE.
  - Read latency is 1 wait cycle.
  - read & ~sel in either state: waitrequest=0, readdata=0.
  - read deasserted while in DATA: return to IDLE, no side effects.
- Atomic 64-bit read: a read of MTIME_LO (IDLE capture) latches mtime[63:32] into shadow_hi; a MTIME_HI read returns shadow_hi. MTIMECMP halves read directly.
- Counting:
  - Prescaler counts 0..PRESCALE while CNT_EN=1.
  - tick when pcount == PRESCALE; pcount then wraps to 0.
  - On tick, mtime += 1 with 64-bit wrap (FFFF_FFFF_FFFF_FFFF -> 0).
  - CNT_EN=0 holds both mtime and pcount.
- Write vs tick collision: a write to either MTIME half overrides the increment of the whole 64-bit value that cycle (the unwritten half keeps its old value, no carry). A PRESCALE write resets pcount to 0.
- irq: registered each cycle as irq <= IRQ_EN & (mtime >= mtimecmp), unsigned 64-bit compare on current register values. One-cycle latency from condition to irq. Stays high until mtimecmp is raised, mtime is rewritten, or IRQ_EN is cleared.
- Simultaneous read and write strobes: not expected from the core. If both occur, the write is performed and the read follows the FSM normally.
- Reset mid-read: FSM returns to IDLE, waitrequest drops asynchronously.

Test Plan:
1. Reset, PRESCALE=0, CNT_EN=1, idle 10 clocks -> read MTIME_LO returns 10 (±1 per read cycle, checked against model); waitrequest high exactly 1 cycle; irq=0.
2. Write MTIMECMP_HI=0, MTIMECMP_LO=20, CTRL=0x3 -> irq rises one clock after mtime reaches 20; write MTIMECMP_LO=FFFF_FFFF -> irq falls next clock.
3. Write MTIME_HI=0, MTIME_LO=FFFF_FFFF, then read LO then HI -> HI read returns shadow captured at LO read (0 or 1, consistent with LO value), never a torn 64-bit value.
4. CTRL PRESCALE=3 -> mtime increments once every 4 clocks; CNT_EN=0 -> mtime frozen across 50 clocks.
5. Write MTIME_LO=0x55 with byteenable=4'b0001 on a tick cycle -> mtime[7:0]=0x55, other bytes unchanged, no increment that cycle.
6. Read at address BASE_ADDR+0x40 -> waitrequest=0, readdata=0; assert reset_n low during read wait cycle -> waitrequest=0 immediately, all registers at reset values.
